bcd_lap_timer: RTL and testbench

- Parametrised successor to the 3-digit stopwatch: a single-clock-domain BCD up/down timer with a configurable digit count.
- Replaces derived 1 Hz/10 Hz clocks with an internal prescaler that generates a clock-enable tick.
- Adds lap capture, countdown mode with preload, and an expiry flag.
- Sits between the debouncers/edge detectors and the seven-segment scanner; `count_bcd` feeds the display directly.

---
 rtl/bcd_lap_timer.sv | 185 ++++++++++++++++++
 tb/tb_bcd_lap_timer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_lap_timer.sv
// Parametrised BCD up/down lap timer: prescaled count enable, lap capture,
// countdown with preload and a sticky expiry flag. All outputs are registered.
module bcd_lap_timer #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int RES_HZ      = 10,
  parameter int DIGITS      = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_stop,
  input  logic                clear,
  input  logic                lap,
  input  logic                mode_down,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic [4*DIGITS-1:0] lap_bcd,
  output logic                lap_valid,
  output logic                running,
  output logic                tick,
  output logic                rollover,
  output logic                expired
);

  localparam int W   = 4 * DIGITS;
  localparam int DIV = CLK_FREQ_HZ / RES_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_chk
      $error("bcd_lap_timer: CLK_FREQ_HZ/RES_HZ must be at least 2");
    end
  endgenerate

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic bcd_all9(input logic [W-1:0] v);
    logic r;
    r = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd9) r = 1'b0;
    end
    return r;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  count_q, count_d;
  logic [W-1:0]  lap_bcd_q, lap_bcd_d;
  logic [W-1:0]  stepped;
  logic          lap_valid_q, lap_valid_d;
  logic          running_q, running_d;
  logic          tick_q, tick_d;
  logic          rollover_q, rollover_d;
  logic          expired_q, expired_d;
  logic          mode_q, mode_d;

  // Direction is taken from the registered copy of mode_down so the step and
  // the rollover flag (computed one cycle ahead) always agree.
  always_comb begin
    if (mode_q) begin
      stepped = (count_q == '0) ? '0 : bcd_dec(count_q);
    end else begin
      stepped = bcd_inc(count_q);
    end

    count_d   = count_q;
    running_d = running_q;
    expired_d = expired_q;

    if (clear) begin
      count_d   = '0;
      running_d = 1'b0;
      expired_d = 1'b0;
    end else if (load) begin
      count_d   = bcd_clamp(load_value);
      running_d = 1'b0;
      expired_d = 1'b0;
    end else begin
      if (tick_q) begin
        count_d = stepped;
        if (mode_q && (stepped == '0)) begin
          running_d = 1'b0;
          expired_d = 1'b1;
        end
      end
      if (start_stop) begin
        if (running_q) begin
          running_d = 1'b0;
        end else if (!(mode_down && (count_q == '0))) begin
          running_d = 1'b1;
          expired_d = 1'b0;
        end
      end
    end

    // Prescaler restarts from 0 on every start, so the first tick is DIV cycles out.
    if (running_q && running_d) begin
      presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
    end else begin
      presc_d = '0;
    end

    tick_d      = running_d && (presc_d == LAST);
    rollover_d  = tick_d && !mode_down && bcd_all9(count_d);
    mode_d      = mode_down;
    lap_bcd_d   = lap ? count_q : lap_bcd_q;
    lap_valid_d = lap;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q     <= '0;
      count_q     <= '0;
      lap_bcd_q   <= '0;
      lap_valid_q <= 1'b0;
      running_q   <= 1'b0;
      tick_q      <= 1'b0;
      rollover_q  <= 1'b0;
      expired_q   <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      count_q     <= count_d;
      lap_bcd_q   <= lap_bcd_d;
      lap_valid_q <= lap_valid_d;
      running_q   <= running_d;
      tick_q      <= tick_d;
      rollover_q  <= rollover_d;
      expired_q   <= expired_d;
      mode_q      <= mode_d;
    end
  end

  assign count_bcd = count_q;
  assign lap_bcd   = lap_bcd_q;
  assign lap_valid = lap_valid_q;
  assign running   = running_q;
  assign tick      = tick_q;
  assign rollover  = rollover_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_bcd_lap_timer.sv
// Scoreboard bench for bcd_lap_timer (DIV = 10, three digits): directed
// stimulus pushes expected tick/lap results, a monitor pops and compares them.
module tb_bcd_lap_timer;

  localparam int DIV_TB = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic        mode_down = 1'b0, load = 1'b0;
  logic [11:0] load_value = 12'h000;
  logic [11:0] count_bcd, lap_bcd;
  logic        lap_valid, running, tick, rollover, expired;

  bcd_lap_timer #(.CLK_FREQ_HZ(100), .RES_HZ(10), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
    .lap(lap), .mode_down(mode_down), .load(load), .load_value(load_value),
    .count_bcd(count_bcd), .lap_bcd(lap_bcd), .lap_valid(lap_valid),
    .running(running), .tick(tick), .rollover(rollover), .expired(expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] cnt;
    logic        roll;
    logic        run;
  } exp_t;

  exp_t        tq[$];
  logic [11:0] lq[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic push_tick(input logic [11:0] c, input logic r, input logic run);
    exp_t e;
    e.cnt = c; e.roll = r; e.run = run;
    tq.push_back(e);
  endtask

  // Monitor: a tick's rollover is checked in the tick cycle, the updated
  // count and running one cycle later; lap results when lap_valid is seen.
  exp_t cur;
  bit   pend = 1'b0;
  always @(negedge clk) begin
    if (pend) begin
      chk("count_after_tick", {20'd0, count_bcd}, {20'd0, cur.cnt});
      chk("running_after_tick", {31'd0, running}, {31'd0, cur.run});
      pend = 1'b0;
    end
    if (tick) begin
      n_assert++;
      if (tq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tick: count %h with no tick expected (t=%0t)", count_bcd, $time);
      end else begin
        cur = tq.pop_front();
        chk("rollover_at_tick", {31'd0, rollover}, {31'd0, cur.roll});
        pend = 1'b1;
      end
    end
    if (lap_valid) begin
      n_assert++;
      if (lq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_lap_valid: lap_bcd %h (t=%0t)", lap_bcd, $time);
      end else begin
        chk("lap_bcd_value", {20'd0, lap_bcd}, {20'd0, lq.pop_front()});
      end
    end
  end

  task automatic pulse_ss();
    @(negedge clk) start_stop = 1'b1;
    @(negedge clk) start_stop = 1'b0;
  endtask

  task automatic pulse_ld(input logic [11:0] v);
    load_value = v;
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < n * DIV_TB + 40) begin
      @(negedge clk);
      cyc++;
      if (tick) seen++;
    end
    n_assert++;
    if (seen != n) begin
      n_fail++;
      $display("FAIL tick_timeout: saw %0d ticks, expected %0d", seen, n);
    end
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"},    {20'd0, count_bcd}, 32'd0);
    chk({tag, "_lap_bcd"},  {20'd0, lap_bcd},   32'd0);
    chk({tag, "_lap_valid"}, {31'd0, lap_valid}, 32'd0);
    chk({tag, "_running"},  {31'd0, running},   32'd0);
    chk({tag, "_tick"},     {31'd0, tick},      32'd0);
    chk({tag, "_rollover"}, {31'd0, rollover},  32'd0);
    chk({tag, "_expired"},  {31'd0, expired},   32'd0);
  endtask

  initial begin
    int k;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // First tick latency and up count 000 -> 010
    for (int i = 1; i <= 10; i++) begin
      logic [11:0] v;
      v = (i == 10) ? 12'h010 : 12'(i);
      push_tick(v, 1'b0, 1'b1);
    end
    pulse_ss();
    k = 1;
    while (!tick && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("first_tick_latency", k, 32'd10);
    wait_ticks(9);
    chk("count_after_10_ticks", {20'd0, count_bcd}, 32'h010);

    // Load while running stops; up-count wraps 999 -> 000 with rollover
    pulse_ld(12'h998);
    chk("load_998_count", {20'd0, count_bcd}, 32'h998);
    chk("load_stops", {31'd0, running}, 32'd0);
    push_tick(12'h999, 1'b0, 1'b1);
    push_tick(12'h000, 1'b1, 1'b1);
    pulse_ss();
    wait_ticks(2);
    chk("running_after_wrap", {31'd0, running}, 32'd1);
    pulse_ss();
    chk("stopped_after_wrap", {31'd0, running}, 32'd0);

    // Countdown to zero: expiry, refused start, clear
    mode_down = 1'b1;
    pulse_ld(12'h002);
    push_tick(12'h001, 1'b0, 1'b1);
    push_tick(12'h000, 1'b0, 1'b0);
    pulse_ss();
    wait_ticks(2);
    chk("expired_set", {31'd0, expired}, 32'd1);
    pulse_ss();
    repeat (15) @(negedge clk);
    chk("start_refused_running", {31'd0, running}, 32'd0);
    chk("start_refused_expired", {31'd0, expired}, 32'd1);
    chk("start_refused_count", {20'd0, count_bcd}, 32'h000);
    pulse_clr();
    chk("clear_expired", {31'd0, expired}, 32'd0);
    mode_down = 1'b0;

    // Lap coincident with a tick
    pulse_ld(12'h047);
    push_tick(12'h048, 1'b0, 1'b1);
    pulse_ss();
    repeat (9) @(negedge clk);
    chk("tick_at_lap", {31'd0, tick}, 32'd1);
    lap = 1'b1;
    lq.push_back(12'h047);
    @(negedge clk) lap = 1'b0;
    @(negedge clk);
    chk("lap_valid_one_cycle", {31'd0, lap_valid}, 32'd0);
    chk("lap_bcd_held", {20'd0, lap_bcd}, 32'h047);
    pulse_ss();

    // clear beats load; load clamps out-of-range nibbles
    pulse_ld(12'h123);
    pulse_ss();
    repeat (4) @(negedge clk);
    load_value = 12'h456;
    clear = 1'b1;
    load  = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    load  = 1'b0;
    chk("clear_over_load_count", {20'd0, count_bcd}, 32'h000);
    chk("clear_over_load_running", {31'd0, running}, 32'd0);
    pulse_ld(12'hFA5);
    chk("load_clamp", {20'd0, count_bcd}, 32'h995);
    chk("lap_kept_over_clear_load", {20'd0, lap_bcd}, 32'h047);

    // Asynchronous reset mid-period
    pulse_ld(12'h321);
    pulse_ss();
    repeat (5) @(negedge clk);
    #1 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    chk("stopped_after_reset_running", {31'd0, running}, 32'd0);
    chk("stopped_after_reset_count", {20'd0, count_bcd}, 32'h000);

    chk("scoreboard_drained", tq.size() + lq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
